// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// datapath mux selects, ALU operations and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    // Instruction classes (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ARM condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// Condition unit: NZCV flag register, condition evaluation, the
// per-instruction CondExReg and final gating of all write enables.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    input  logic       next_pc,
    input  logic       branch,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       ir_w,
    input  logic       rd_is_pc,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       ir_write
);

    logic [3:0] flags;
    logic       cond_ex;
    logic       cond_ex_reg;
    logic       n, z, c, v;
    logic       pcs;

    assign {n, z, c, v} = flags;

    // Flag register: NZ and CV groups update independently, only when the
    // executing instruction requests it and its condition passed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] && cond_ex_reg) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex_reg) flags[1:0] <= alu_flags[1:0];
        end
    end

    // Evaluate the condition field against the current flags
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // cond_ex unassigned, which would infer a latch.
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Capture the condition outcome once per instruction, leaving DECODE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cond_ex_reg <= 1'b0;
        else if (cond_latch) cond_ex_reg <= cond_ex;
    end

    // Gate write enables; reset forces every write off immediately
    assign pcs       = branch | (reg_w & rd_is_pc);
    assign pc_write  = reset & (next_pc | (pcs & cond_ex_reg));
    assign reg_write = reset & reg_w & cond_ex_reg & ~rd_is_pc;
    assign mem_write = reset & mem_w & cond_ex_reg;
    assign ir_write  = reset & ir_w;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM and ALU decoder, with condition
// logic and write gating delegated to cond_unit.
module multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    state_t     state, next_state;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op;
    logic       cmd_valid, cmd_arith;
    logic [1:0] flag_w;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    // Next-state and raw per-state control outputs
    always_comb begin
        next_state = state;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        alu_op     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        unique case (state)
            S_FETCH: begin
                next_state = S_DECODE;
                ir_w       = 1'b1;
                next_pc    = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                // ALUOut picks up PC+8 here so it can stand in for R15
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                unique case (op)
                    OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  next_state = S_MEMADR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                next_state = funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB    = SRCB_IMM;
            end
            S_MEMRD: begin
                next_state = S_MEMWB;
                AdrSrc     = 1'b1;
            end
            S_MEMWB: begin
                next_state = S_FETCH;
                ResultSrc  = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                next_state = S_FETCH;
                AdrSrc     = 1'b1;
                mem_w      = 1'b1;
            end
            S_EXECR: begin
                next_state = S_ALUWB;
                alu_op     = 1'b1;
            end
            S_EXECI: begin
                next_state = S_ALUWB;
                ALUSrcB    = SRCB_IMM;
                alu_op     = 1'b1;
            end
            S_ALUWB: begin
                next_state = S_FETCH;
                reg_w      = 1'b1;
            end
            S_BRANCH: begin
                next_state = S_FETCH;
                ALUSrcA    = SRCA_ALUOUT;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                branch     = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // ALU decoder: unsupported commands fall back to ADD with no flag write
    always_comb begin
        ALUControl = ALU_ADD;
        cmd_valid  = 1'b0;
        cmd_arith  = 1'b0;
        if (alu_op) begin
            unique case (funct[4:1])
                CMD_ADD: begin ALUControl = ALU_ADD; cmd_valid = 1'b1; cmd_arith = 1'b1; end
                CMD_SUB: begin ALUControl = ALU_SUB; cmd_valid = 1'b1; cmd_arith = 1'b1; end
                CMD_AND: begin ALUControl = ALU_AND; cmd_valid = 1'b1; end
                CMD_ORR: begin ALUControl = ALU_ORR; cmd_valid = 1'b1; end
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

    assign flag_w[1] = alu_op & funct[0] & cmd_valid;
    assign flag_w[0] = alu_op & funct[0] & cmd_arith;

    cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (state == S_DECODE),
        .next_pc    (next_pc),
        .branch     (branch),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .ir_w       (ir_w),
        .rd_is_pc   (rd == 4'b1111),
        .pc_write   (PCWrite),
        .reg_write  (RegWrite),
        .mem_write  (MemWrite),
        .ir_write   (IRWrite)
    );

endmodule
